// File: rtl/alu_pkg.sv
// Shared definitions for the iterative-shift execute ALU.
// Holds op_ctr encodings, FSM state type and shift-step legality helpers.
package alu_pkg;

  localparam logic [2:0] OP_ADD = 3'b000;
  localparam logic [2:0] OP_AND = 3'b001;
  localparam logic [2:0] OP_OR  = 3'b010;
  localparam logic [2:0] OP_XOR = 3'b011;
  localparam logic [2:0] OP_SFT = 3'b100;
  localparam logic [2:0] OP_SLT = 3'b110;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } state_t;

  localparam int SHIFT_STEP_MIN = 1;
  localparam int SHIFT_STEP_MAX = 8;

  function automatic bit step_legal(input int s);
    return (s == 1) || (s == 2) || (s == 4) || (s == 8);
  endfunction

endpackage

// File: rtl/alu_shift_iter.sv
// Iterative shifter: up to SHIFT_STEP bits per cycle until rem hits zero.
// Ports: start loads a/shamt/dir/arith; busy while rem!=0; done marks the
// final step, with value carrying the fully shifted word in that cycle.
module alu_shift_iter
  import alu_pkg::*;
#(
  parameter int XLEN       = 32,
  parameter int SHIFT_STEP = 1
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            start,
  input  logic [XLEN-1:0] a,
  input  logic [4:0]      shamt,
  input  logic            dir,
  input  logic            arith,
  output logic            busy,
  output logic            done,
  output logic [XLEN-1:0] value
);

  localparam logic [4:0] STEP5 = 5'(SHIFT_STEP);

  logic [XLEN-1:0] work;
  logic [4:0]      rem;
  logic            dir_q;
  logic            arith_q;
  logic [4:0]      k;
  logic [XLEN-1:0] step_val;

  assign k    = (rem < STEP5) ? rem : STEP5;
  assign busy = (rem != 5'd0);
  assign done = busy && (rem <= STEP5);

  // Arithmetic right shift keeps work's MSB, which stays equal to a[31]
  // for the whole operation, so the fill is always the original sign.
  always_comb begin
    step_val = work;
    if (!dir_q)
      step_val = work << k;
    else if (arith_q)
      step_val = $unsigned($signed(work) >>> k);
    else
      step_val = work >> k;
  end

  assign value = step_val;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      work    <= '0;
      rem     <= '0;
      dir_q   <= 1'b0;
      arith_q <= 1'b0;
    end else if (start) begin
      work    <= a;
      rem     <= shamt;
      dir_q   <= dir;
      arith_q <= arith;
    end else if (busy) begin
      work <= step_val;
      rem  <= rem - k;
    end
  end

endmodule

// File: rtl/alu_seq_exec.sv
// RV32 execute ALU: single-cycle add/logic/compare, iterative shifts.
// Ports: in_valid/in_ready accept a,b + controls; out_valid/out_ready
// hand off result with zero (a==b) and less (a<b per sig_ctr) flags.
module alu_seq_exec
  import alu_pkg::*;
#(
  parameter int XLEN       = 32,
  parameter int SHIFT_STEP = 1
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [XLEN-1:0] a,
  input  logic [XLEN-1:0] b,
  input  logic            sub_ctr,
  input  logic            sft_ctr,
  input  logic            al_ctr,
  input  logic [2:0]      op_ctr,
  input  logic            sig_ctr,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [XLEN-1:0] result,
  output logic            zero,
  output logic            less
);

  if (!step_legal(SHIFT_STEP) || XLEN != 32) begin : g_bad_param
    $error("alu_seq_exec: unsupported XLEN or SHIFT_STEP");
  end

  state_t state_q;
  state_t state_d;

  logic            accept;
  logic            is_sft;
  logic            sh_start;
  logic            sh_busy;
  logic            sh_done;
  logic [XLEN-1:0] sh_value;
  logic [XLEN:0]   diff;
  logic            ovf;
  logic            less_c;
  logic            eq_c;
  logic [XLEN-1:0] res_c;
  state_t          start_state;

  assign in_ready  = (state_q == IDLE) ||
                     ((state_q == DONE) && out_ready);
  assign accept    = in_valid && in_ready;
  assign out_valid = (state_q == DONE);

  assign is_sft      = (op_ctr == OP_SFT);
  assign sh_start    = accept && is_sft && (b[4:0] != 5'd0);
  assign start_state = (is_sft && (b[4:0] != 5'd0)) ? SHIFT : DONE;

  // Flags always come from a - b; bit XLEN of the zero-extended
  // difference is the unsigned borrow.
  assign diff   = {1'b0, a} - {1'b0, b};
  assign ovf    = (a[XLEN-1] ^ b[XLEN-1]) &
                  (diff[XLEN-1] ^ a[XLEN-1]);
  assign less_c = sig_ctr ? (diff[XLEN-1] ^ ovf) : diff[XLEN];
  assign eq_c   = (a == b);

  always_comb begin
    res_c = '0;
    case (op_ctr)
      OP_ADD:  res_c = sub_ctr ? (a - b) : (a + b);
      OP_AND:  res_c = a & b;
      OP_OR:   res_c = a | b;
      OP_XOR:  res_c = a ^ b;
      OP_SFT:  res_c = a;
      OP_SLT:  res_c = {{(XLEN-1){1'b0}}, less_c};
      default: res_c = '0;
    endcase
  end

  alu_shift_iter #(
    .XLEN       (XLEN),
    .SHIFT_STEP (SHIFT_STEP)
  ) u_shift (
    .clk   (clk),
    .rst   (rst),
    .start (sh_start),
    .a     (a),
    .shamt (b[4:0]),
    .dir   (sft_ctr),
    .arith (al_ctr),
    .busy  (sh_busy),
    .done  (sh_done),
    .value (sh_value)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= IDLE;
    else     state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE: begin
        if (accept) state_d = start_state;
      end
      SHIFT: begin
        if (sh_done)       state_d = DONE;
        else if (!sh_busy) state_d = IDLE;
      end
      DONE: begin
        if (out_ready) state_d = accept ? start_state : IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      result <= '0;
      zero   <= 1'b0;
      less   <= 1'b0;
    end else if (accept) begin
      zero <= eq_c;
      less <= less_c;
      if (!sh_start) result <= res_c;
    end else if ((state_q == SHIFT) && sh_done) begin
      result <= sh_value;
    end
  end

endmodule

// File: tb/tb_alu_seq_exec.sv
// Directed bench for alu_seq_exec with SHIFT_STEP=1.
// Vector table for single ops plus hand sequences for multi-cycle cases.
module tb_alu_seq_exec;

  typedef struct {
    logic [31:0] a;
    logic [31:0] b;
    logic        sub;
    logic        sft;
    logic        al;
    logic [2:0]  op;
    logic        sig;
    logic [31:0] res;
    logic        z;
    logic        l;
    int          lat;
  } vec_t;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] a;
  logic [31:0] b;
  logic        sub_ctr;
  logic        sft_ctr;
  logic        al_ctr;
  logic [2:0]  op_ctr;
  logic        sig_ctr;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] result;
  logic        zero;
  logic        less;

  int errors = 0;
  int checks = 0;

  vec_t vt[15];

  alu_seq_exec #(
    .XLEN       (32),
    .SHIFT_STEP (1)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .a         (a),
    .b         (b),
    .sub_ctr   (sub_ctr),
    .sft_ctr   (sft_ctr),
    .al_ctr    (al_ctr),
    .op_ctr    (op_ctr),
    .sig_ctr   (sig_ctr),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .result    (result),
    .zero      (zero),
    .less      (less)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name,
                     input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic drive(input vec_t v);
    a       = v.a;
    b       = v.b;
    sub_ctr = v.sub;
    sft_ctr = v.sft;
    al_ctr  = v.al;
    op_ctr  = v.op;
    sig_ctr = v.sig;
  endtask

  // Entered and left at posedge+1 with the DUT idle.
  task automatic do_op(input vec_t v, input string tag);
    int lat;
    bit rdy_low;
    drive(v);
    in_valid  = 1'b1;
    out_ready = 1'b0;
    #1;
    chk({tag, " in_ready"}, 32'(in_ready), 32'd1);
    @(posedge clk); #1;
    in_valid = 1'b0;
    lat      = 1;
    rdy_low  = 1'b1;
    while (!out_valid && lat < 100) begin
      if (in_ready) rdy_low = 1'b0;
      @(posedge clk); #1;
      lat++;
    end
    chk({tag, " latency"}, 32'(lat), 32'(v.lat));
    chk({tag, " result"}, result, v.res);
    chk({tag, " zero"}, 32'(zero), 32'(v.z));
    chk({tag, " less"}, 32'(less), 32'(v.l));
    if (v.lat > 1)
      chk({tag, " busy ready"}, 32'(rdy_low), 32'd1);
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
    chk({tag, " drain"}, 32'(out_valid), 32'd0);
  endtask

  initial begin
    vec_t v;
    //          a             b             sub  sft  al   op      sig  res           z    l    lat
    vt[0]  = '{32'h7FFFFFFF, 32'h00000001, 1'b0,1'b0,1'b0,3'b000,1'b1,32'h80000000,1'b0,1'b0,1};
    vt[1]  = '{32'h00000005, 32'h00000005, 1'b1,1'b0,1'b0,3'b000,1'b1,32'h00000000,1'b1,1'b0,1};
    vt[2]  = '{32'hFFFFFFFF, 32'h00000001, 1'b0,1'b0,1'b0,3'b110,1'b1,32'h00000001,1'b0,1'b1,1};
    vt[3]  = '{32'hFFFFFFFF, 32'h00000001, 1'b0,1'b0,1'b0,3'b110,1'b0,32'h00000000,1'b0,1'b0,1};
    vt[4]  = '{32'hF0F0F0F0, 32'h0FF00FF0, 1'b0,1'b0,1'b0,3'b001,1'b0,32'h00F000F0,1'b0,1'b0,1};
    vt[5]  = '{32'hF0F0F0F0, 32'h0FF00FF0, 1'b0,1'b0,1'b0,3'b010,1'b0,32'hFFF0FFF0,1'b0,1'b0,1};
    vt[6]  = '{32'hF0F0F0F0, 32'h0FF00FF0, 1'b0,1'b0,1'b0,3'b011,1'b0,32'hFF00FF00,1'b0,1'b0,1};
    vt[7]  = '{32'h80000000, 32'h0000001F, 1'b0,1'b1,1'b1,3'b100,1'b0,32'hFFFFFFFF,1'b0,1'b0,32};
    vt[8]  = '{32'h80000000, 32'h0000001F, 1'b0,1'b1,1'b0,3'b100,1'b0,32'h00000001,1'b0,1'b0,32};
    vt[9]  = '{32'h00000001, 32'h00000025, 1'b0,1'b0,1'b0,3'b100,1'b0,32'h00000020,1'b0,1'b1,6};
    vt[10] = '{32'h00001234, 32'h00000020, 1'b0,1'b0,1'b0,3'b100,1'b0,32'h00001234,1'b0,1'b0,1};
    vt[11] = '{32'h00000003, 32'h00000003, 1'b0,1'b0,1'b0,3'b101,1'b0,32'h00000000,1'b1,1'b0,1};
    vt[12] = '{32'h00000001, 32'h00000002, 1'b0,1'b0,1'b0,3'b111,1'b0,32'h00000000,1'b0,1'b1,1};
    vt[13] = '{32'h80000000, 32'h00000001, 1'b0,1'b0,1'b0,3'b110,1'b1,32'h00000001,1'b0,1'b1,1};
    vt[14] = '{32'h00000003, 32'h0000001F, 1'b0,1'b0,1'b1,3'b100,1'b0,32'h80000000,1'b0,1'b1,32};

    rst       = 1'b1;
    in_valid  = 1'b0;
    out_ready = 1'b0;
    a = '0; b = '0;
    sub_ctr = 1'b0; sft_ctr = 1'b0; al_ctr = 1'b0;
    op_ctr = 3'b000; sig_ctr = 1'b0;

    repeat (2) @(posedge clk);
    #1;
    chk("rst out_valid", 32'(out_valid), 32'd0);
    chk("rst result", result, 32'd0);
    chk("rst zero", 32'(zero), 32'd0);
    chk("rst less", 32'(less), 32'd0);
    chk("rst in_ready", 32'(in_ready), 32'd1);
    @(negedge clk);
    rst = 1'b0;
    @(posedge clk); #1;

    for (int i = 0; i < 15; i++)
      do_op(vt[i], $sformatf("v%0d", i));

    // Back-pressure, then back-to-back accept while draining.
    v = '{32'd10, 32'd20, 1'b0,1'b0,1'b0,3'b000,1'b0,32'd30,1'b0,1'b1,1};
    drive(v);
    in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    for (int c = 0; c < 3; c++) begin
      chk($sformatf("bp%0d valid", c), 32'(out_valid), 32'd1);
      chk($sformatf("bp%0d result", c), result, 32'd30);
      chk($sformatf("bp%0d less", c), 32'(less), 32'd1);
      chk($sformatf("bp%0d zero", c), 32'(zero), 32'd0);
      @(posedge clk); #1;
    end
    v = '{32'd6, 32'd3, 1'b0,1'b0,1'b0,3'b011,1'b0,32'd5,1'b0,1'b0,1};
    drive(v);
    in_valid  = 1'b1;
    out_ready = 1'b1;
    #1;
    chk("b2b in_ready", 32'(in_ready), 32'd1);
    @(posedge clk); #1;
    in_valid = 1'b0;
    chk("b2b valid", 32'(out_valid), 32'd1);
    chk("b2b result", result, 32'd5);
    chk("b2b less", 32'(less), 32'd0);
    @(posedge clk); #1;
    out_ready = 1'b0;
    chk("b2b drain", 32'(out_valid), 32'd0);

    // Reset in the middle of a 31-bit shift.
    drive(vt[7]);
    in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    repeat (9) @(posedge clk);
    #2;
    chk("mid in_ready", 32'(in_ready), 32'd0);
    rst = 1'b1;
    #1;
    chk("mid out_valid", 32'(out_valid), 32'd0);
    chk("mid result", result, 32'd0);
    chk("mid in_ready idle", 32'(in_ready), 32'd1);
    @(negedge clk);
    rst = 1'b0;
    @(posedge clk); #1;
    do_op(vt[9], "post_rst");
    do_op(vt[0], "post_rst_add");

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/alu_seq_exec.md
Name: alu_seq_exec

Overview:
- RV32 execute-stage ALU that consumes the decoded control bundle (sub_ctr, sft_ctr, al_ctr, op_ctr, sig_ctr) and the two 32-bit operands.
- Produces a registered result plus branch flags over a valid/ready handshake.
- Add, logic and compare complete in one cycle. Shifts run iteratively through a small shift sub-unit, SHIFT_STEP bits per cycle, to save area.
- Sits between the ALU control decoder and the writeback/branch logic.

Parameters:
- XLEN, 32, operand/result width; only 32 is supported.
- SHIFT_STEP, 1, maximum bits shifted per cycle; legal values are 1, 2, 4, 8.

Ports:
- clk  in  1  rising-edge clock
- rst  in  1  asynchronous, active-high reset
- in_valid  in  1  operands and control are valid
- in_ready  out  1  block can accept a new operation
- a  in  32  operand A
- b  in  32  operand B; b[4:0] is the shift amount
- sub_ctr  in  1  0 = add, 1 = subtract (adder path)
- sft_ctr  in  1  0 = shift left, 1 = shift right
- al_ctr  in  1  1 = arithmetic right shift, 0 = logical
- op_ctr  in  3  result select: 000 adder, 001 and, 010 or, 011 xor, 100 shifter, 110 set-less-than; 101 and 111 are undefined
- sig_ctr  in  1  1 = signed compare, 0 = unsigned compare
- out_valid  out  1  result and flags are valid
- out_ready  in  1  consumer accepts the result
- result  out  32  ALU result
- zero  out  1  a == b
- less  out  1  a < b, signed or unsigned per sig_ctr

Behaviour:
- Reset, asynchronous, any state: state=IDLE, out_valid=0, result=0, zero=0, less=0, internal shift counter=0. An operation in progress is discarded.
- in_ready = (state==IDLE) | (state==DONE & out_ready). A new operation can be accepted in the same cycle the previous result is consumed.
- Accept happens on a rising edge with in_valid & in_ready. At the accept edge:
  - zero and less are computed from a - b, independent of op_ctr and sub_ctr, and registered.
  - Compare uses sig_ctr: signed uses overflow-corrected sign; unsigned uses borrow.
- Non-shift ops (op_ctr != 100) take one cycle. The result is registered at the accept edge; state goes to DONE; out_valid=1 in the next cycle.
  - 000: a + b when sub_ctr=0, a - b when sub_ctr=1, both modulo 2^32.
  - 001: a & b.
  - 010: a | b.
  - 011: a ^ b.
  - 110: {31'b0, less}.
  - 101 or 111: result 0. Flags are still computed normally.
- Shift ops (op_ctr == 100):
  - shamt = b[4:0]; upper bits of b are ignored.
  - If shamt = 0: behaves like a non-shift op, result = a, DONE after one cycle.
  - Otherwise: load work = a and rem = shamt; state = SHIFT.
  - Each SHIFT cycle shifts work by k = min(SHIFT_STEP, rem) and does rem -= k.
  - Left shifts fill with 0. Right shifts fill with a[31] when al_ctr=1, else 0.
  - al_ctr is ignored for left shifts.
  - When rem reaches 0, result = work and state = DONE.
  - Total latency from accept to out_valid = 1 + ceil(shamt/SHIFT_STEP) edges.
- DONE: out_valid=1. result, zero and less stay stable while out_ready=0. On out_ready=1:
  - if in_valid=1, accept the new op in the same edge;
  - otherwise go to IDLE with out_valid=0.
- in_ready=0 during SHIFT. Inputs presented then are ignored and must be held by the producer.
- Control inputs are sampled only at the accept edge.
- FSM states: IDLE -> (accept, shift with shamt!=0) SHIFT -> DONE. IDLE -> (accept, other) DONE. DONE -> IDLE, or back-to-back to SHIFT/DONE.

Decomposition:
- Shared package alu_pkg holds:
  - op_ctr encodings: OP_ADD=000, OP_AND=001, OP_OR=010, OP_XOR=011, OP_SFT=100, OP_SLT=110;
  - the FSM state typedef (IDLE, SHIFT, DONE);
  - SHIFT_STEP legality check constants.
- One sub-module, alu_shift_iter, holds the work register, rem counter and fill logic. It has a start/busy/done interface and is instantiated once.
- Adder, logic and compare stay in the top level.

Test Plan:
- add/sub: a=0x7FFFFFFF, b=1, op=000, sub=0 -> result 0x80000000 one cycle after accept; sub=1 with a=5, b=5 -> result 0, zero=1, less=0.
- slt signed vs unsigned: a=0xFFFFFFFF, b=1, op=110 -> sig=1 gives result 1, less=1; sig=0 gives result 0, less=0.
- shifts with SHIFT_STEP=1: a=0x80000000, b=31, sft=1.
  - al=1 -> result 0xFFFFFFFF, out_valid on the 32nd edge after accept, in_ready=0 throughout.
  - al=0 -> result 0x00000001.
  - b=0x25 (shamt=5), sft=0, a=1 -> result 0x20.
- back-pressure and back-to-back: hold out_ready=0 for 3 cycles -> result and flags stable; then assert out_ready together with a new in_valid -> the new op is accepted in the same edge, with no idle bubble.
- reset mid-shift: assert rst during cycle 10 of a 31-bit shift -> out_valid=0 and result=0 immediately, state IDLE; the next op completes correctly.
- undefined op_ctr=101: a=3, b=3 -> result 0, zero=1, out_valid after one cycle.
